// File: rtl/cycle_sequencer.sv
// rtl/cycle_sequencer.sv - stallable, haltable three-phase instruction cycle sequencer
module cycle_sequencer #(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 16
) (
  input  logic             i_CLOCK,
  input  logic             i_RESET,
  input  logic             i_MEMREADY,
  input  logic             i_HALT,
  input  logic             i_STEP,
  input  logic             i_CLRFAULT,
  output logic [1:0]       o_STATE,
  output logic             o_CYCLEX,
  output logic             o_CYCLEY,
  output logic             o_CYCLEZ,
  output logic             o_HALTED,
  output logic             o_FAULT,
  output logic [CNT_W-1:0] o_INSCOUNT
);

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_STACK   = 3'd1,
    ST_OPERAND = 3'd2,
    ST_HALT    = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

  // Last wait count that may still be followed by a ready; one more idle cycle trips the watchdog.
  localparam logic [7:0]       LP_WAIT_LAST = 8'(WAIT_LIMIT - 1);
  localparam logic [CNT_W-1:0] LP_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_next;
  logic [7:0]       r_wait;
  logic [7:0]       w_wait_next;
  logic             r_step;
  logic             w_step_next;
  logic [CNT_W-1:0] r_inscount;
  logic             w_cyclex;
  logic             w_cycley;
  logic             w_cyclez;

  // Next-state, wait counter, step latch and phase strobes.
  always_comb begin
    w_state_next = r_state;
    w_wait_next  = r_wait;
    w_step_next  = r_step;
    w_cyclex     = 1'b0;
    w_cycley     = 1'b0;
    w_cyclez     = 1'b0;
    o_STATE      = 2'd0;

    case (r_state)
      ST_FETCH, ST_STACK, ST_OPERAND: begin
        if (i_MEMREADY) begin
          // Ready beats the watchdog even on the cycle the limit is reached.
          w_wait_next = 8'd0;
          case (r_state)
            ST_FETCH: w_state_next = ST_STACK;
            ST_STACK: w_state_next = ST_OPERAND;
            default: begin
              // Instruction boundary: the only place a halt or step completion takes effect.
              if (i_HALT || r_step) begin
                w_state_next = ST_HALT;
                w_step_next  = 1'b0;
              end else begin
                w_state_next = ST_FETCH;
              end
            end
          endcase
        end else if (r_wait == LP_WAIT_LAST) begin
          // The interrupted instruction is abandoned, including any pending single step.
          w_state_next = ST_FAULT;
          w_wait_next  = 8'd0;
          w_step_next  = 1'b0;
        end else begin
          w_wait_next = r_wait + 8'd1;
        end
      end
      ST_HALT: begin
        if (!i_HALT) begin
          w_state_next = ST_FETCH;
        end else if (i_STEP) begin
          w_state_next = ST_FETCH;
          w_step_next  = 1'b1;
        end
      end
      ST_FAULT: begin
        if (i_CLRFAULT) begin
          w_state_next = ST_HALT;
        end
      end
      default: begin
        w_state_next = ST_FETCH;
        w_wait_next  = 8'd0;
        w_step_next  = 1'b0;
      end
    endcase

    case (r_state)
      ST_FETCH:   o_STATE = 2'd1;
      ST_STACK:   o_STATE = 2'd2;
      ST_OPERAND: o_STATE = 2'd3;
      default:    o_STATE = 2'd0;
    endcase

    // Strobes are suppressed while reset is asserted so nothing downstream acts on a dying phase.
    w_cyclex = !i_RESET && i_MEMREADY && (r_state == ST_FETCH);
    w_cycley = !i_RESET && i_MEMREADY && (r_state == ST_STACK);
    w_cyclez = !i_RESET && i_MEMREADY && (r_state == ST_OPERAND);
  end

  // State, wait counter, step latch and retired-instruction counter registers.
  always_ff @(posedge i_CLOCK) begin
    if (i_RESET) begin
      r_state    <= ST_FETCH;
      r_wait     <= 8'd0;
      r_step     <= 1'b0;
      r_inscount <= '0;
    end else begin
      r_state <= w_state_next;
      r_wait  <= w_wait_next;
      r_step  <= w_step_next;
      if (w_cyclez) begin
        r_inscount <= r_inscount + LP_CNT_ONE;
      end
    end
  end

  assign o_CYCLEX   = w_cyclex;
  assign o_CYCLEY   = w_cycley;
  assign o_CYCLEZ   = w_cyclez;
  assign o_HALTED   = (r_state == ST_HALT);
  assign o_FAULT    = (r_state == ST_FAULT);
  assign o_INSCOUNT = r_inscount;

endmodule

// File: tb/tb_cycle_sequencer.sv
// tb/tb_cycle_sequencer.sv - directed self-checking bench for cycle_sequencer
module tb_cycle_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       memready = 1'b1;
  logic       halt = 1'b0;
  logic       step = 1'b0;
  logic       clrfault = 1'b0;
  logic [1:0] state;
  logic       cx;
  logic       cy;
  logic       cz;
  logic       halted;
  logic       fault;
  logic [3:0] inscount;

  int n_checks = 0;
  int n_pass   = 0;

  cycle_sequencer #(.WAIT_LIMIT(16), .CNT_W(4)) u_dut (
    .i_CLOCK    (clk),
    .i_RESET    (rst),
    .i_MEMREADY (memready),
    .i_HALT     (halt),
    .i_STEP     (step),
    .i_CLRFAULT (clrfault),
    .o_STATE    (state),
    .o_CYCLEX   (cx),
    .o_CYCLEY   (cy),
    .o_CYCLEZ   (cz),
    .o_HALTED   (halted),
    .o_FAULT    (fault),
    .o_INSCOUNT (inscount)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_state", state, 1);
    check("rst_halted", halted, 0);
    check("rst_fault", fault, 0);
    check("rst_count", inscount, 0);

    // 1: zero-wait running, 3 clocks per instruction
    for (int i = 0; i < 9; i++) begin
      check("run_state", state, (i % 3) + 1);
      check("run_x", cx, (i % 3) == 0);
      check("run_y", cy, (i % 3) == 1);
      check("run_z", cz, (i % 3) == 2);
      tick();
    end
    check("run_count", inscount, 3);

    // 2: two wait cycles in STACK
    tick();
    memready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("wait_state", state, 2);
      check("wait_y", cy, 0);
      tick();
    end
    memready = 1'b1;
    #1;
    check("wait_state3", state, 2);
    check("wait_y3", cy, 1);
    tick();
    check("wait_operand", state, 3);
    check("wait_nofault", fault, 0);
    tick();
    check("wait_count", inscount, 4);

    // 3: watchdog trip in FETCH, then clear to HALT
    memready = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 15) begin
        check("wd_pre_state", state, 1);
        check("wd_pre_fault", fault, 0);
      end
    end
    check("wd_fault", fault, 1);
    check("wd_state", state, 0);
    check("wd_halted", halted, 0);
    memready = 1'b1;
    halt = 1'b1;
    step = 1'b1;
    #1;
    check("wd_no_strobe", cx | cy | cz, 0);
    tick();
    step = 1'b0;
    check("wd_hold_fault", fault, 1);
    check("wd_hold_state", state, 0);
    clrfault = 1'b1;
    tick();
    clrfault = 1'b0;
    check("clr_halted", halted, 1);
    check("clr_fault", fault, 0);
    tick();
    check("clr_stay", halted, 1);
    check("clr_count", inscount, 4);
    halt = 1'b0;
    tick();
    check("resume_state", state, 1);

    // 4: halt raised in STACK, then single step
    tick();
    halt = 1'b1;
    #1;
    check("h_stack", state, 2);
    tick();
    check("h_operand", state, 3);
    tick();
    check("h_halted", halted, 1);
    check("h_state", state, 0);
    check("h_count", inscount, 5);
    tick();
    check("h_stay", halted, 1);
    step = 1'b1;
    tick();
    step = 1'b0;
    #1;
    check("s_x", {cx, cy, cz}, 3'b100);
    tick();
    check("s_y", {cx, cy, cz}, 3'b010);
    tick();
    check("s_z", {cx, cy, cz}, 3'b001);
    tick();
    check("s_halted", halted, 1);
    check("s_count", inscount, 6);
    check("s_no_strobe", {cx, cy, cz}, 3'b000);
    tick();
    check("s_stay", halted, 1);

    // Halt withdrawn before the boundary: no halt
    halt = 1'b0;
    tick();
    check("r_fetch", state, 1);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    tick();
    tick();
    check("nh_state", state, 1);
    check("nh_count", inscount, 7);

    // 6: ready on the cycle the limit would be reached
    memready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
    end
    memready = 1'b1;
    #1;
    check("lim_x", cx, 1);
    check("lim_state", state, 1);
    tick();
    check("lim_adv", state, 2);
    check("lim_nofault", fault, 0);
    tick();
    tick();
    check("lim_count", inscount, 8);

    // 5: counter wrap with CNT_W=4, then reset mid-OPERAND
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_count", inscount, 0);
    for (int i = 0; i < 51; i++) begin
      tick();
    end
    check("wrap_count", inscount, 1);
    check("wrap_state", state, 1);
    tick();
    tick();
    check("mid_operand", state, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mrst_state", state, 1);
    check("mrst_count", inscount, 0);
    check("mrst_z", cz, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
